// File: rtl/a_trace_ram_ctrl_64_if.sv
// Bus bundle between the trace RAM sequencer, the compressor, the trace RAM and the host.
// master = the surroundings (compressor, RAM, host); slave = the sequencer.
interface a_trace_ram_ctrl_64_if #(
  parameter int ADDR_W = 13
);
  // Handshakes: capt_valid_i, rd_en_i, start_i and stop_i are single-cycle strobes with no
  // backpressure; each strobe is one transaction.
  // The strobe is either honoured or dropped according to the sequencer state.
  // rd_valid_o marks the cycle its rd_data_o is valid.
  logic              start_i;
  logic              stop_i;
  logic              capt_valid_i;
  logic [63:0]       capt_data_i;
  logic              rd_en_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [63:0]       ram_rdata_i;
  logic              run_verif_o;
  logic              ram_we_o;
  logic              ram_re_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [63:0]       ram_wdata_o;
  logic              rd_valid_o;
  logic [63:0]       rd_data_o;
  logic              busy_o;
  logic              done_o;
  logic              full_o;
  logic              ovf_o;
  logic [ADDR_W:0]   count_o;
  logic [1:0]        state_o;

  modport master (
    output start_i, stop_i, capt_valid_i, capt_data_i, rd_en_i, rd_addr_i, ram_rdata_i,
    input  run_verif_o, ram_we_o, ram_re_o, ram_addr_o, ram_wdata_o, rd_valid_o, rd_data_o,
           busy_o, done_o, full_o, ovf_o, count_o, state_o
  );

  modport slave (
    input  start_i, stop_i, capt_valid_i, capt_data_i, rd_en_i, rd_addr_i, ram_rdata_i,
    output run_verif_o, ram_we_o, ram_re_o, ram_addr_o, ram_wdata_o, rd_valid_o, rd_data_o,
           busy_o, done_o, full_o, ovf_o, count_o, state_o
  );
endinterface

// File: rtl/a_trace_ram_ctrl_64.sv
// Trace sequencer for the 64-bit compressed-trace path: arms the compressor, stores its words
// in the single-port trace RAM, auto-stops near full, drains, then serves host readback.
module a_trace_ram_ctrl_64 #(
  parameter int                ADDR_W     = 13,
  parameter logic [ADDR_W-1:0] FULL_LEVEL = 13'h1FF7,
  parameter int                DRAIN_CYC  = 8
) (
  input  logic                  clk_ref,
  input  logic                  rst_n,
  a_trace_ram_ctrl_64_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int                DC_W       = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DC_W-1:0]   DRAIN_LAST = DC_W'(DRAIN_CYC - 1);
  localparam logic [ADDR_W:0]   DEPTH      = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [DC_W-1:0]   drain_cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count;
  logic              run_verif, ram_we, ram_re, rd_valid, busy, done, full, ovf;
  logic [ADDR_W-1:0] ram_addr;
  logic [63:0]       ram_wdata;

  logic wr_window, rd_window, wr_accept, wr_do, wr_drop, rd_accept, hit_full;

  assign wr_window = (state == S_RUN) || (state == S_DRAIN);
  assign rd_window = (state == S_IDLE) || (state == S_DONE);
  assign wr_accept = bus.capt_valid_i && wr_window;
  // Once every RAM location holds a word, further words are dropped instead of wrapping.
  assign wr_do     = wr_accept && (count != DEPTH);
  assign wr_drop   = wr_accept && (count == DEPTH);
  assign rd_accept = bus.rd_en_i && rd_window;
  assign hit_full  = (state == S_RUN) && wr_do && (wr_ptr == FULL_LEVEL - ADDR_W'(1));

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      run_verif <= 1'b0;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      full      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      ram_we   <= wr_do;
      ram_re   <= rd_accept && !wr_do;
      rd_valid <= ram_re;
      if (wr_do) begin
        ram_addr  <= wr_ptr;
        ram_wdata <= bus.capt_data_i;
        wr_ptr    <= wr_ptr + ADDR_W'(1);
        count     <= count + (ADDR_W+1)'(1);
      end else if (rd_accept) begin
        ram_addr <= bus.rd_addr_i;
      end
      if (wr_drop) ovf <= 1'b1;

      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start_i) begin
            state     <= S_RUN;
            run_verif <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            wr_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            ovf       <= 1'b0;
            drain_cnt <= '0;
          end
        end
        S_RUN: begin
          if (hit_full || bus.stop_i) begin
            state     <= S_DRAIN;
            run_verif <= 1'b0;
            drain_cnt <= '0;
            if (hit_full) full <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DC_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.run_verif_o = run_verif;
  assign bus.ram_we_o    = ram_we;
  assign bus.ram_re_o    = ram_re;
  assign bus.ram_addr_o  = ram_addr;
  assign bus.ram_wdata_o = ram_wdata;
  assign bus.rd_valid_o  = rd_valid;
  // RAM data arrives one cycle after the read strobe and is passed straight through.
  assign bus.rd_data_o   = rd_valid ? bus.ram_rdata_i : 64'd0;
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.full_o      = full;
  assign bus.ovf_o       = ovf;
  assign bus.count_o     = count;
  assign bus.state_o     = state;
endmodule
